// File: rtl/mul_acc.sv
`default_nettype none
// ============================================================================
// mul_acc: accumulates unsigned multiplier products into W = 2N+G bit sums.
// Optional build macro MUL_ACC_SAT_EN clamps acc to all ones on overflow.
// Revision: 1.0
// ============================================================================
module mul_acc #(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N-1:0]       prod,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [2*N+G-1:0]     acc,
  output logic [7:0]           cnt,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = 2*N + G;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  logic           accept;
  logic [W:0]     sum;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign acc       = acc_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;

  assign accept = in_valid & in_ready;
  assign sum    = {1'b0, acc_q} + {{(G+1){1'b0}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = {{G{1'b0}}, prod};
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
`ifdef MUL_ACC_SAT_EN
          // Once saturated, acc stays pinned for the rest of the group.
          if (sum[W] || ovf_q) begin
            acc_d = {W{1'b1}};
          end else begin
            acc_d = sum[W-1:0];
          end
`else
          acc_d = sum[W-1:0];
`endif
          ovf_d   = ovf_q | sum[W];
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_acc.sv
`default_nettype none
// ============================================================================
// tb_mul_acc: directed self-checking bench for mul_acc at N=8, G=4 (W=20).
// Revision: 1.0
// ============================================================================
module tb_mul_acc;

  localparam int N = 8;
  localparam int G = 4;
  localparam int W = 2*N + G;

  logic           clk;
  logic           rst;
  logic [2*N-1:0] prod;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [W-1:0]   acc;
  logic [7:0]     cnt;
  logic           ovf;
  logic           out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mul_acc #(.N(N), .G(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .prod      (prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .acc       (acc),
    .cnt       (cnt),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat for a single edge, then idle the input; outputs settle by #1.
  task automatic beat(input logic [2*N-1:0] p, input logic last);
    prod     = p;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (acc !== 20'd0)     begin n_fail++; $display("FAIL reset_acc got=%0h exp=0", acc); end
    n_checks++; if (cnt !== 8'd0)      begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_checks++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    beat(16'd6, 1'b0);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_acc_state in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    beat(16'd7, 1'b0);
    beat(16'd8, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    n_checks++; if (acc !== 20'd21)     begin n_fail++; $display("FAIL basic_acc got=%0d exp=21", acc); end
    n_checks++; if (cnt !== 8'd3)       begin n_fail++; $display("FAIL basic_cnt got=%0d exp=3", cnt); end
    n_checks++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL basic_done_in_ready got=%b exp=0", in_ready); end
    consume();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    n_checks++; if (acc !== 20'd21 || cnt !== 8'd3) begin n_fail++; $display("FAIL basic_idle_hold acc=%0d cnt=%0d exp 21/3", acc, cnt); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_acc;
`ifdef MUL_ACC_SAT_EN
    exp_acc = 20'hFFFFF;
`else
    exp_acc = 20'h0DE11;
`endif
    for (int i = 0; i < 16; i++) beat(16'hFE01, 1'b0);
    n_checks++; if (acc !== 20'hFE010) begin n_fail++; $display("FAIL ovf16_acc got=%0h exp=fe010", acc); end
    n_checks++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL ovf16_ovf got=%b exp=0", ovf); end
    n_checks++; if (cnt !== 8'd16)     begin n_fail++; $display("FAIL ovf16_cnt got=%0d exp=16", cnt); end
    beat(16'hFE01, 1'b1);
    n_checks++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL ovf17_ovf got=%b exp=1", ovf); end
    n_checks++; if (cnt !== 8'd17)     begin n_fail++; $display("FAIL ovf17_cnt got=%0d exp=17", cnt); end
    n_checks++; if (acc !== exp_acc)   begin n_fail++; $display("FAIL ovf17_acc got=%0h exp=%0h", acc, exp_acc); end
    consume();
    n_checks++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL ovf_sticky_idle got=%b exp=1", ovf); end
    beat(16'd2, 1'b1);
    n_checks++; if (ovf !== 1'b0 || acc !== 20'd2) begin n_fail++; $display("FAIL ovf_clear ovf=%b acc=%0h exp 0/2", ovf, acc); end
    consume();
  endtask

  task automatic test_back_to_back();
    beat(16'd5, 1'b1);
    prod      = 16'd9;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc !== 20'd5 || cnt !== 8'd1 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d in_ready=%b out_valid=%b acc=%0d cnt=%0d ovf=%b exp 0/1/5/1/0", i, in_ready, out_valid, acc, cnt, ovf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc !== 20'd5) begin n_fail++; $display("FAIL stall_exit out_valid=%b in_ready=%b acc=%0d exp 0/1/5", out_valid, in_ready, acc); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || acc !== 20'd9 || cnt !== 8'd1) begin n_fail++; $display("FAIL stall_pending out_valid=%b acc=%0d cnt=%0d exp 1/9/1", out_valid, acc, cnt); end
    consume();
  endtask

  task automatic test_single();
    beat(16'h1234, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || acc !== 20'h01234 || cnt !== 8'd1) begin n_fail++; $display("FAIL single out_valid=%b acc=%0h cnt=%0d exp 1/1234/1", out_valid, acc, cnt); end
    consume();
  endtask

  task automatic test_async_reset();
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (acc !== 20'd0 || cnt !== 8'd0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset acc=%0d cnt=%0d ovf=%b out_valid=%b in_ready=%b exp 0/0/0/0/1", acc, cnt, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    beat(16'd3, 1'b0);
    beat(16'd4, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || acc !== 20'd7 || cnt !== 8'd2) begin n_fail++; $display("FAIL reset_regroup out_valid=%b acc=%0d cnt=%0d exp 1/7/2", out_valid, acc, cnt); end
    consume();
  endtask

  task automatic test_gap();
    beat(16'd10, 1'b0);
    beat(16'd20, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (acc !== 20'd30 || cnt !== 8'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_hold acc=%0d cnt=%0d out_valid=%b exp 30/2/0", acc, cnt, out_valid); end
    beat(16'd30, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || acc !== 20'd60 || cnt !== 8'd3) begin n_fail++; $display("FAIL gap_final out_valid=%b acc=%0d cnt=%0d exp 1/60/3", out_valid, acc, cnt); end
    consume();
  endtask

  task automatic test_cnt_sat();
    for (int i = 0; i < 299; i++) beat(16'd1, 1'b0);
    beat(16'd1, 1'b1);
    n_checks++; if (cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_sat got=%0d exp=255", cnt); end
    n_checks++; if (acc !== 20'd300 || ovf !== 1'b0) begin n_fail++; $display("FAIL cnt_sat_acc acc=%0d ovf=%b exp 300/0", acc, ovf); end
    consume();
  endtask

  initial begin
    rst       = 1'b1;
    prod      = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_single();
    test_async_reset();
    test_gap();
    test_cnt_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
